// File: rtl/key_bounce_gen_pkg.sv
// Shared types and constants for the key bounce emulator.
package key_bounce_gen_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StBounce = 2'd1,
    StSettle = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_HOLD_CYC = 3000;

  // Fibonacci taps 16,14,13,11 as a mask over bits [15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/key_bounce_gen_lfsr.sv
// 16-bit Fibonacci LFSR with step enable; used by key_bounce_gen when
// KEY_BOUNCE_LFSR_EN is defined to randomise the bounce pattern.
module bounce_lfsr
  import key_bounce_gen_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        step,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lfsr <= LFSR_SEED;
    end else if (step) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/key_bounce_gen.sv
// Mechanical key emulator: bounce for a programmed number of cycles, then hold
// the target level. Define KEY_BOUNCE_LFSR_EN for LFSR-gated bounce toggles.
module key_bounce_gen
  import key_bounce_gen_pkg::*;
#(
  parameter int unsigned BOUNCE_W   = 12,
  parameter int unsigned HOLD_CYC   = DEFAULT_HOLD_CYC,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_level,
  input  logic [BOUNCE_W-1:0] cmd_bounce,
  output logic                key_out,
  output logic                busy,
  output logic                done
);

  localparam int unsigned   HoldW    = $clog2(HOLD_CYC + 1);
  localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_CYC);

  state_e              state;
  logic [BOUNCE_W-1:0] bounce_cnt;
  logic [HoldW-1:0]    hold_cnt;
  logic                level_lat;
  logic                toggle_en;

`ifdef KEY_BOUNCE_LFSR_EN
  logic [15:0] lfsr;

  bounce_lfsr u_lfsr (
    .clk  (clk),
    .nrst (nrst),
    .step (1'b1),
    .lfsr (lfsr)
  );

  assign toggle_en = lfsr[0];
`else
  assign toggle_en = 1'b1;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= StIdle;
      key_out    <= IDLE_LEVEL;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      bounce_cnt <= '0;
      hold_cnt   <= '0;
      level_lat  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          // Ready reopens only one cycle after done so done and accept never coincide
          if (done) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (cmd_valid && cmd_ready) begin
            level_lat  <= cmd_level;
            bounce_cnt <= cmd_bounce;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            if (cmd_bounce != '0) begin
              state <= StBounce;
            end else begin
              state    <= StSettle;
              hold_cnt <= HoldInit;
            end
          end
        end
        StBounce: begin
          if (toggle_en) key_out <= ~key_out;
          bounce_cnt <= bounce_cnt - 1'b1;
          if (bounce_cnt == BOUNCE_W'(1)) begin
            state    <= StSettle;
            hold_cnt <= HoldInit;
          end
        end
        StSettle: begin
          key_out  <= level_lat;
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt == HoldW'(1)) begin
            done  <= 1'b1;
            state <= StIdle;
          end
        end
        default: begin
          state     <= StIdle;
          key_out   <= IDLE_LEVEL;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
